alu_mul_seq: RTL and testbench

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

---
 rtl/alu_mul_seq.sv | 148 ++++++++++++++
 tb/tb_alu_mul_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Sequential 16x16 shift-add multiplier driving an external combinational ALU.
// Define ALU_MUL_EARLY_TERM_EN to stop once the remaining multiplier bits are all zero.
module alu_mul_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] a_in,
   input  logic [15:0] b_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] product,
   output logic        ofl,
   output logic [15:0] alu_A,
   output logic [15:0] alu_B,
   output logic [2:0]  alu_Op,
   output logic        alu_Cin,
   output logic        alu_sign,
   input  logic [15:0] alu_Out,
   input  logic        alu_OFL,
   input  logic        alu_Zero
);

   // state   | meaning
   // S_IDLE  | waiting for start, operands captured on start
   // S_CHECK | decide terminate / add / shift
   // S_ADD   | acc += mcand through the ALU
   // S_SHIFT | mcand <<= 1 through the ALU, mplier >>= 1, cnt--
   // S_DONE  | one-cycle done pulse
   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ADD, S_SHIFT, S_DONE} state_t;

   localparam logic [2:0] OP_SLL = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd4;
   localparam logic [2:0] OP_AND = 3'd7;

   state_t      state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] mcand_q, mcand_d;
   logic [15:0] mplier_q, mplier_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        ofl_r_q, ofl_r_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] product_q, product_d;
   logic        ofl_q, ofl_d;
   logic        term;
   logic        unused_zero;

   assign unused_zero = alu_Zero;
   assign alu_Cin     = 1'b0;
   assign alu_sign    = 1'b0;

`ifdef ALU_MUL_EARLY_TERM_EN
   assign term = (mplier_q == 16'd0);
`else
   assign term = (cnt_q == 5'd0);
`endif

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      ofl_r_d   = ofl_r_q;
      product_d = product_q;
      ofl_d     = ofl_q;
      alu_A     = 16'd0;
      alu_B     = 16'd0;
      alu_Op    = OP_AND;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d    = 16'd0;
               mcand_d  = a_in;
               mplier_d = b_in;
               cnt_d    = 5'd16;
               ofl_r_d  = 1'b0;
               state_d  = S_CHECK;
            end
         end
         S_CHECK: begin
            if (term)             state_d = S_DONE;
            else if (mplier_q[0]) state_d = S_ADD;
            else                  state_d = S_SHIFT;
         end
         S_ADD: begin
            alu_A   = acc_q;
            alu_B   = mcand_q;
            alu_Op  = OP_ADD;
            acc_d   = alu_Out;
            if (alu_OFL) ofl_r_d = 1'b1;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            alu_A    = mcand_q;
            alu_B    = 16'h0001;
            alu_Op   = OP_SLL;
            mcand_d  = alu_Out;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 5'd1;
            // a set bit leaving mcand still has multiplier bits left to weight it
            if (mcand_q[15] && ((mplier_q >> 1) != 16'd0)) ofl_r_d = 1'b1;
            state_d  = S_CHECK;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // result is published as DONE is entered so it is valid alongside done
      if (state_d == S_DONE && state_q != S_DONE) begin
         product_d = acc_d;
         ofl_d     = ofl_r_d;
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_q     <= 16'd0;
         mcand_q   <= 16'd0;
         mplier_q  <= 16'd0;
         cnt_q     <= 5'd0;
         ofl_r_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= 16'd0;
         ofl_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         ofl_r_q   <= ofl_r_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
         ofl_q     <= ofl_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
   assign ofl     = ofl_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU; expectations follow
// ALU_MUL_EARLY_TERM_EN when it is defined for the build.
module tb_alu_mul_seq;

`ifdef ALU_MUL_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [15:0] a_in, b_in;
   logic        busy, done, ofl;
   logic [15:0] product;
   logic [15:0] alu_A, alu_B, alu_Out;
   logic [2:0]  alu_Op;
   logic        alu_Cin, alu_sign, alu_OFL, alu_Zero;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [2:0]  ops [0:7];

   always #5 clk = ~clk;

   alu_mul_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
      .busy(busy), .done(done), .product(product), .ofl(ofl),
      .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op), .alu_Cin(alu_Cin),
      .alu_sign(alu_sign), .alu_Out(alu_Out), .alu_OFL(alu_OFL), .alu_Zero(alu_Zero)
   );

   always_comb begin
      alu_Out = 16'd0;
      alu_OFL = 1'b0;
      case (alu_Op)
         3'd1: alu_Out = alu_A << alu_B[3:0];
         3'd4: {alu_OFL, alu_Out} = {1'b0, alu_A} + {1'b0, alu_B};
         3'd7: alu_Out = alu_A & alu_B;
         default: ;
      endcase
   end
   assign alu_Zero = (alu_Out == 16'd0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start at edge k; lat is n such that done is high in cycle k+n (0 = timeout).
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat,
                         output logic [15:0] p, output logic o);
      @(negedge clk);
      a_in = a; b_in = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; p = 16'hxxxx; o = 1'bx;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (n <= 8) ops[n-1] = alu_Op;
         if (done) begin
            lat = n; p = product; o = ofl;
            break;
         end
      end
   endtask

   task automatic do_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_p, input logic exp_o,
                         input int lat_early, input int lat_full);
      int lat; logic [15:0] p; logic o;
      run_op(a, b, lat, p, o);
      check({tag, "_product"}, p, exp_p);
      check({tag, "_ofl"}, o, exp_o);
      check({tag, "_latency"}, lat, EARLY ? lat_early : lat_full);
   endtask

   initial begin
      int lat, gap, seen;
      logic [15:0] p;
      logic o;

      rst_n = 1'b0; start = 1'b0; a_in = 16'd0; b_in = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_product", product, 16'd0);
      check("rst_ofl", ofl, 1'b0);
      check("rst_alu_op", alu_Op, 3'd7);
      check("rst_alu_a", alu_A, 16'd0);
      check("alu_cin_sign", {alu_Cin, alu_sign}, 2'b00);
      rst_n = 1'b1;

      // latency: early = 2*bitlen(b)+popcount(b)+2, full = 32+popcount(b)+2
      do_vec("a5_b0",      16'h0005, 16'h0000, 16'h0000, 1'b0,  2, 34);
      do_vec("a7_b3",      16'h0007, 16'h0003, 16'h0015, 1'b0,  8, 36);
      for (int i = 0; i < 8; i++) begin
         logic [2:0] exp_op;
         case (i)
            0, 3: exp_op = 3'd7;
            1, 4: exp_op = 3'd4;
            2, 5: exp_op = 3'd1;
            6:    exp_op = 3'd7;
            default: exp_op = EARLY ? 3'd7 : 3'd1;
         endcase
         check($sformatf("a7_b3_op%0d", i), ops[i], exp_op);
      end
      do_vec("a100_b100",  16'h0100, 16'h0100, 16'h0000, 1'b1, 21, 35);
      do_vec("affff_bffff",16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 50, 50);
      do_vec("a3_b1",      16'h0003, 16'h0001, 16'h0003, 1'b0,  5, 35);
      do_vec("a0_b9",      16'h0000, 16'h0009, 16'h0000, 1'b0, 12, 36);
      do_vec("a1234_b10",  16'h1234, 16'h0010, 16'h2340, 1'b1, 13, 35);
      do_vec("aff_b101",   16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 22, 36);

      // product held while idle and operands change
      a_in = 16'hAAAA; b_in = 16'h5555;
      repeat (3) @(negedge clk);
      check("hold_product", product, 16'hFFFF);
      check("idle_busy", busy, 1'b0);

      // reset in the middle of 3*3, sampled at edge k+3
      @(negedge clk);
      a_in = 16'd3; b_in = 16'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_product", product, 16'd0);
      check("midrst_ofl", ofl, 1'b0);
      start = 1'b1;
      @(negedge clk);
      check("rst_over_start_busy", busy, 1'b0);
      start = 1'b0; rst_n = 1'b1;
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("midrst_no_done", seen, 0);

      do_vec("a2_b4", 16'h0002, 16'h0004, 16'h0008, 1'b0, 9, 35);

      // start held high: back-to-back operations separated by one IDLE cycle
      @(negedge clk);
      a_in = 16'd3; b_in = 16'd1; start = 1'b1;
      lat = 0;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (done) begin lat = n; break; end
      end
      check("held_first_done", lat > 0, 1'b1);
      gap = 0;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (done) begin gap = n; break; end
      end
      start = 1'b0;
      check("held_done_spacing", gap, EARLY ? 6 : 36);
      check("held_product", product, 16'h0003);
      repeat (2) @(negedge clk);
      check("held_release_idle", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
